// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder slice.
// rv32i_types carries the byte write mask used across the datapath;
// mem_responder_types carries the responder FSM encoding, word type and
// the jitter LFSR seed (used only when MEM_RESPONDER_JITTER_EN is defined).

package rv32i_types;
    typedef logic [3:0] rv32i_mem_wmask;
endpackage

package mem_responder_types;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    typedef logic [31:0] mem_word_t;

    // Seed loaded into the jitter LFSR on reset.
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Wait counter width: covers LATENCY-2 plus up to 3 jitter cycles.
    localparam int CNT_W = 5;
endpackage

// File: rtl/mem_responder_if.sv
// mem_read/mem_write/mem_resp handshake bundle between the CPU (master)
// and the memory responder (slave).
//
// Handshake: the master raises mem_read or mem_write (level) with address,
// wdata and byte_enable, and holds it until it sees mem_resp. The slave
// commits the request at the capture cycle, then pulses mem_resp for exactly
// one cycle; mem_rdata is meaningful only in that cycle and is 0 otherwise.
// The master must drop the request in the cycle after mem_resp, otherwise it
// is taken as a new transaction. dbg_state mirrors the responder FSM state.

interface mem_responder_if
    import mem_responder_types::*, rv32i_types::*;
();
    logic            mem_read;
    logic            mem_write;
    logic [31:0]     mem_address;
    mem_word_t       mem_wdata;
    rv32i_mem_wmask  mem_byte_enable;
    logic            mem_resp;
    mem_word_t       mem_rdata;
    mem_resp_state_t dbg_state;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata, dbg_state
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata, dbg_state
    );
endinterface

// File: rtl/mem_responder_array.sv
// Single-port word array with per-byte write enables and combinational read.
// Contents are not reset.

module mem_responder_array
    import mem_responder_types::*, rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  rv32i_mem_wmask        wmask,
    input  mem_word_t             wdata,
    output mem_word_t             rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    mem_word_t mem [DEPTH];

    // Byte-lane write: only lanes selected by wmask are updated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && wmask[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: captures one request, waits a fixed latency,
// then pulses mem_resp with registered read data. Writes commit at the edge
// that ends the response cycle.
// Optional macro MEM_RESPONDER_JITTER_EN adds 0..3 extra wait cycles per
// transaction, drawn from an 8-bit LFSR that is reseeded on reset.

module mem_responder
    import mem_responder_types::*, rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    // Number of BUSY cycles between capture and RESP without jitter.
    localparam logic [CNT_W-1:0] BASE_WAIT = CNT_W'(LATENCY - 1);

    mem_resp_state_t       state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    mem_word_t             wdata_q, wdata_d;
    rv32i_mem_wmask        be_q, be_d;
    logic                  wr_q, wr_d;
    logic                  resp_q, resp_d;
    mem_word_t             rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] in_idx;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic                  arr_we;
    mem_word_t             arr_rdata;
    logic                  capture;
    logic [CNT_W-1:0]      wait_total;
    logic [CNT_W-1:0]      extra_wait;
    logic                  unused_addr_bits;

    assign in_idx           = bus.mem_address[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{bus.mem_address[31:ADDR_WIDTH+2], bus.mem_address[1:0]};
    assign capture          = (state_q == IDLE) && (bus.mem_read || bus.mem_write);

`ifdef MEM_RESPONDER_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    // Taps 8,6,5,4; advances once per captured request.
    assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign extra_wait = {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};

    // LFSR next value.
    always_comb begin
        lfsr_d = lfsr_q;
        if (capture) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end
    end

    // LFSR register, reseeded on reset so jitter repeats per reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign extra_wait = '0;
`endif

    assign wait_total = BASE_WAIT + extra_wait;

    // Array is addressed by the live request while idle so a latency-1 read
    // can be registered straight from capture; otherwise by the captured index.
    assign arr_addr = (state_q == IDLE) ? in_idx : idx_q;
    assign arr_we   = (state_q == RESP) && wr_q;

    mem_responder_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .addr  (arr_addr),
        .we    (arr_we),
        .wmask (be_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        resp_d  = 1'b0;
        rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    idx_d   = in_idx;
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    // A simultaneous read and write is treated as a write.
                    wr_d    = bus.mem_write;
                    if (wait_total == '0) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        rdata_d = bus.mem_write ? '0 : arr_rdata;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = wait_total - 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    rdata_d = wr_q ? '0 : arr_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; an in-flight request is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 and LATENCY=1), random
// and directed requests, reference memory model and a response scoreboard.

module tb_mem_responder;
    import mem_responder_types::*;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int L0    = 2;
    localparam int L1    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if if0 ();
    mem_responder_if if1 ();

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(L0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(L1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Reference memories and scoreboard queues (expected data, request cycle).
    logic [31:0] ref0 [DEPTH];
    logic [31:0] ref1 [DEPTH];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int          req_c0 [$];
    int          req_c1 [$];
    int          lat_log [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic get_resp(int sel);
        return (sel == 0) ? if0.mem_resp : if1.mem_resp;
    endfunction

    task automatic drive(int sel, bit rd, bit wr, logic [31:0] addr, logic [31:0] wd, logic [3:0] be);
        if (sel == 0) begin
            if0.mem_read = rd; if0.mem_write = wr; if0.mem_address = addr;
            if0.mem_wdata = wd; if0.mem_byte_enable = be;
        end else begin
            if1.mem_read = rd; if1.mem_write = wr; if1.mem_address = addr;
            if1.mem_wdata = wd; if1.mem_byte_enable = be;
        end
    endtask

    // Issue one request, update the model, push the expectation, wait for resp.
    task automatic req(int sel, bit rd, bit wr, logic [31:0] addr, logic [31:0] wd,
                       logic [3:0] be, bit hold);
        int          idx;
        int          n;
        logic [31:0] word;
        logic [31:0] e;
        @(negedge clk);
        drive(sel, rd, wr, addr, wd, be);
        idx  = int'((addr >> 2) % DEPTH);
        word = (sel == 0) ? ref0[idx] : ref1[idx];
        if (wr) begin
            for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
            if (sel == 0) ref0[idx] = word; else ref1[idx] = word;
            e = 32'h0;
        end else begin
            e = word;
        end
        if (sel == 0) begin exp_q0.push_back(e); req_c0.push_back(cyc); end
        else          begin exp_q1.push_back(e); req_c1.push_back(cyc); end
        if (!hold) begin
            @(negedge clk);
            drive(sel, 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
        end
        n = 0;
        while (!get_resp(sel) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL resp_timeout: dut %0d got no mem_resp required within 40 cycles", sel);
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Monitor: pop and compare on every mem_resp; rdata must be 0 otherwise.
    task automatic mon(int sel);
        logic        r;
        logic [31:0] d;
        logic [31:0] e;
        int          rc;
        int          lat;
        int          l;
        r = (sel == 0) ? if0.mem_resp  : if1.mem_resp;
        d = (sel == 0) ? if0.mem_rdata : if1.mem_rdata;
        l = (sel == 0) ? L0 : L1;
        if (r) begin
            if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: dut %0d mem_resp=1 required 0 (cycle %0d)", sel, cyc);
            end else begin
                if (sel == 0) begin e = exp_q0.pop_front(); rc = req_c0.pop_front(); end
                else          begin e = exp_q1.pop_front(); rc = req_c1.pop_front(); end
                chk($sformatf("rdata_dut%0d", sel), d, e);
                lat = cyc - rc;
`ifdef MEM_RESPONDER_JITTER_EN
                checks++;
                if (lat < l || lat > l + 3) begin
                    errors++;
                    $display("FAIL latency_dut%0d: got %0d required %0d..%0d", sel, lat, l, l + 3);
                end
                if (sel == 0) lat_log.push_back(lat);
`else
                chk($sformatf("latency_dut%0d", sel), 32'(lat), 32'(l));
`endif
            end
        end else begin
            chk($sformatf("rdata_idle_dut%0d", sel), d, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run1 [$];
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_resp0",  32'(if0.mem_resp), 32'h0);
        chk("reset_rdata0", if0.mem_rdata, 32'h0);
        chk("reset_state0", 32'(if0.dbg_state), 32'(IDLE));
        chk("reset_resp1",  32'(if1.mem_resp), 32'h0);
        rst = 1'b0;

        // Initialise every word so all later reads are predictable.
        for (int i = 0; i < DEPTH; i++) req(0, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);
        for (int i = 0; i < DEPTH; i++) req(1, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);

        // Directed cases on the LATENCY=2 instance.
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1);
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        req(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b1);
        req(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
        req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        chk("partial_model", ref0[8], 32'h11BB33DD);
        req(0, 1'b0, 1'b1, 32'h404, 32'hCAFEF00D, 4'hF, 1'b1);
        req(0, 1'b1, 1'b0, 32'h7, 32'h0, 4'h0, 1'b1);
        req(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1);
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        req(0, 1'b1, 1'b1, 32'h30, 32'h5, 4'hF, 1'b1);
        req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1);
        req(0, 1'b0, 1'b1, 32'h50, 32'hFFFFFFFF, 4'h0, 1'b1);
        req(0, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b1);

        // Reset while the write is in BUSY: no response, no array update.
        req(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(if0.dbg_state), 32'(IDLE));
        chk("midrst_resp",  32'(if0.mem_resp), 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1);

        // LATENCY=1 instance: mid-cycle drop and plain traffic.
        req(1, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b1);
        req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);

        // Random traffic on both instances.
        for (int i = 0; i < 200; i++) begin
            bit rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = (!rd) ? 1'b1 : ($urandom_range(0, 7) == 0);
            req(i % 2, rd, wr, $urandom, $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 3) != 0));
        end

`ifdef MEM_RESPONDER_JITTER_EN
        for (int run = 0; run < 2; run++) begin
            repeat (2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            lat_log.delete();
            for (int i = 0; i < 16; i++) req(0, 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b1);
            if (run == 0) run1 = lat_log;
        end
        chk("jitter_count", 32'(lat_log.size()), 32'(run1.size()));
        for (int i = 0; i < 16 && i < lat_log.size() && i < run1.size(); i++)
            chk($sformatf("jitter_seq_%0d", i), 32'(lat_log[i]), 32'(run1[i]));
`endif

        repeat (10) @(negedge clk);
        chk("queue0_empty", 32'(exp_q0.size()), 32'h0);
        chk("queue1_empty", 32'(exp_q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multicycle memory responder: the slave end of the mem_read/mem_write/mem_resp handshake that the CPU control FSM drives.
- Holds a word-organised on-chip array with byte-enabled writes.
- Answers each request after a fixed, parameterised latency, so fetch, ldr and str wait states are exercised in simulation and on FPGA.
- Sits between the datapath's MAR/MDR/data_out and nothing else; it is the whole memory system for mp0-style bring-up.

Parameters:
- ADDR_WIDTH, 8, word-index bits; depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from the request-sample cycle to the mem_resp cycle; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  read request, level, held by initiator until mem_resp.
- mem_write  in  1  write request, level, held until mem_resp.
- mem_address  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_byte_enable  in  4  write lane mask; bit i enables byte i (bits 8i+7:8i).
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid only while mem_resp=1.

Behaviour:
- Reset (async, any time including mid-transaction): state=IDLE, mem_resp=0, mem_rdata=0, counter=0. Any in-flight transaction is discarded and no array write occurs. The array itself is not reset.
- Index: word index = mem_address[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo depth.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read or mem_write is high, capture address, wdata, byte_enable and op.
  - Go to RESP if LATENCY==1; otherwise go to BUSY with counter=LATENCY-2.
- BUSY: decrement counter. When counter==0, go to RESP.
- RESP:
  - mem_resp=1.
  - For a read, mem_rdata = array[captured index], with bytes read as a full word regardless of mask.
  - For a write, the array lanes selected by the captured mask are updated at the edge ending RESP, and mem_rdata=0.
  - Always go to IDLE next.
- Latency: with the request first high in cycle N, mem_resp is high in cycle N+LATENCY.
- Outputs are registered. mem_rdata=0 whenever mem_resp=0.
- The request is committed at capture. Dropping mem_read/mem_write while in BUSY does not cancel it. Input changes after capture are ignored.
- mem_read and mem_write both high at capture: the write wins, and the read is not performed.
- Back-to-back requests: if the request is still high in the cycle after RESP, IDLE treats it as a new transaction. The initiator must deassert in the cycle following mem_resp, which the control FSM does.
- Read-after-write to the same word returns the new data, because the write commits before the next capture.
- mem_byte_enable=0 on a write: handshake completes and the array is unchanged.

Optional Feature:
- Macro MEM_RESPONDER_JITTER_EN.
- When defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on rst) advances once per capture. Its bits [1:0] add 0..3 extra BUSY cycles to that transaction, so latency is LATENCY..LATENCY+3 and is deterministic per reset.
- When undefined: latency is exactly LATENCY, and no LFSR logic exists.

Decomposition:
- Shared package mem_responder_types:
  - enum mem_resp_state_t {IDLE, BUSY, RESP}.
  - typedef mem_word_t (logic [31:0]).
  - LFSR_SEED constant.
- Reuse rv32i_mem_wmask from rv32i_types for the mask.
- One natural sub-module: mem_responder_array. It is a single-port, 2**ADDR_WIDTH x 32 array with a 4-lane byte write enable and combinational read, instantiated once. The FSM stays in the top level.

Test Plan:
- Reset, then write 32'hDEADBEEF to 32'h0000_0010 with mask 4'b1111 (LATENCY=2). Response: mem_resp high exactly 2 cycles after the request edge, one cycle wide. Then read 32'h10: mem_rdata=32'hDEADBEEF during mem_resp, 0 otherwise.
- Partial write: word at 32'h20 holds 32'h11223344; write 32'hAABBCCDD with mask 4'b0101. A subsequent read returns 32'h11BB33DD.
- Aliasing and alignment: ADDR_WIDTH=8, write 32'hCAFEF00D to 32'h0000_0404. A read of 32'h0000_0007 returns 32'hCAFEF00D, and a read of 32'h0000_0004 returns the same value via bits [9:2].
- Robustness:
  - Assert read at 32'h10 for one cycle only, then drop it: mem_resp still pulses after LATENCY.
  - Assert read and write together with 32'h5 and mask 4'hF at 32'h30: a write occurs, mem_rdata=0, and a later read gives 32'h00000005.
- Reset mid-transaction: start a write of 32'h12345678 to 32'h40 (old value 32'h0), assert rst in BUSY. mem_resp never pulses and a later read of 32'h40 returns 32'h0. Repeat with LATENCY=1 and confirm mem_resp in the cycle right after the request.
- With MEM_RESPONDER_JITTER_EN: 16 reads, with every latency in [LATENCY, LATENCY+3] and a sequence identical across two runs from reset.
